nios_sd_loader_irq_ctrl: RTL and testbench
==========================================

# nios_sd_loader_irq_ctrl

Avalon-MM interrupt aggregator between the SD-loader peripherals and the Nios II IRQ input. It sits directly downstream of the interval timer: the timer's `irq` drives source 0, and the SD/SPI and UART interrupts drive the remaining sources. Each source is latched as a per-source pending bit (level or rising-edge mode) and masked. The block drives one registered `irq` and exposes a priority-encoded active-source ID for fast dispatch.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..16.
- `clk` input, 1 bit: the single clock for the whole block.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `address` input, 3 bits: word address of the register being accessed.
- `chipselect` input, 1 bit: slave select.
- `write_n` input, 1 bit: active-low write strobe.
- `writedata` input, 16 bits: write data.
- `readdata` output, 16 bits: registered read data.
- `irq_in` input, `NUM_SRC` bits: source interrupts, synchronous to `clk`. Bit 0 is the timer.
- `irq` output, 1 bit: registered aggregate interrupt to the CPU.

## Operation
- Register map. Writes take effect when `chipselect && !write_n`.
  - Address 0, PENDING: read returns pending bits. Writing 1 to a bit clears it (W1C), and only for edge-mode sources.
  - Address 1, MASK: read/write enable bits.
  - Address 2, MODE: read/write. 1 selects rising-edge mode, 0 selects level mode.
  - Address 3, FORCE: write sets pending bits of edge-mode sources. Reads return 0.
  - Address 4, ACTIVE: read returns `{valid, 11'b0, id[3:0]}`. `id` is the lowest-index bit of `PENDING & MASK`, and `valid` is 1 when any such bit is set. Writes are ignored.
  - Address 5, RAW: read returns `irq_in_q`, the registered copy of `irq_in`.
  - Addresses 6 and 7: reads return 0, writes are ignored.
- Bits at or above `NUM_SRC` read 0 in every register, and writes to them are ignored.
- `irq_in_q` registers `irq_in` on every cycle.
- Level mode, per source: `pending[i] <= irq_in[i]`. W1C and FORCE have no effect.
- Edge mode, per source: `pending[i]` is set on `irq_in[i] & ~irq_in_q[i]` or a FORCE write of 1. It is cleared by a W1C write of 1.
- Set and clear in the same cycle: set wins, so the pending bit stays 1.
- Mode change:
  - `irq_in_q` tracks continuously in both modes, so a level→edge switch while the input is high produces no edge.
  - An edge→level switch makes the pending bit follow `irq_in` from the next cycle.
- `irq <= |(pending & mask)` on every cycle.
- Masking never clears pending. Unmasking a pending source raises `irq` one cycle later.

## Timing
- Reset values: `readdata` = 0, `irq` = 0, pending = 0, mask = 0, mode = 0 (all level), `irq_in_q` = 0.
- Interrupt latency: with `irq_in[i]` high and masked-in at edge k, pending is set at edge k and `irq` rises at edge k+1.
- Clear latency: a W1C at edge k clears pending at edge k, and `irq` falls at edge k+1 if no other source is active.
- Reads: there is no read strobe. `readdata` is registered from the `address` mux on every cycle, independent of `chipselect`. Read latency is 1 cycle.
- A read of PENDING in the same cycle as a write returns the pre-write value.
- Reset mid-operation: asynchronous assertion zeroes all state and `irq` immediately. There is no pending carry-over.
- After reset release, a source already high is latched in level mode at the first edge. Because `irq_in_q` resets to 0, it would count as an edge in edge mode, but mode is level at reset, so no spurious edge occurs.

## Structure
- Package `nios_sd_loader_irq_pkg`:
  - Address constants `IRQ_ADDR_PENDING` through `IRQ_ADDR_RAW`.
  - `IRQ_MAX_SRC = 16`.
  - `IRQ_ACTIVE_VALID_BIT = 15`.
- Sub-module `nios_sd_loader_irq_prio_enc`: combinational, `NUM_SRC`-wide masked-pending input to `{valid, id[3:0]}`, lowest index first. The top level contains the registers, the edge logic and the read mux.

## Test plan
- Reset, then read addresses 0–7: all return 0 and `irq` = 0. Hold `irq_in` = 0x01 with mask 0: `irq` stays 0 and PENDING reads 0x0001.
- Mask = 0x01, level mode, `irq_in[0]` pulses high for 3 cycles: pending stays high for 3 cycles and `irq` is high for the same 3 cycles, delayed by 1 cycle.
- Mode = 0x01, mask = 0x01, `irq_in[0]` pulses for 1 cycle:
  - PENDING latches 0x0001 and `irq` stays 1 indefinitely.
  - Writing 0x0001 to address 0 makes `irq` fall after 1 cycle.
- Edge mode: a W1C to bit 0 in the same cycle as a new rising edge on `irq_in[0]` leaves pending set (set wins).
- Mask = 0x0C with edge sources 2 and 3 FORCEd (write 0x000C to address 3): ACTIVE reads 0x8002. After W1C of bit 2, ACTIVE reads 0x8003. After W1C of bit 3, ACTIVE reads 0x0000.
- Assert `reset_n` low while `irq` = 1 with PENDING = 0x0081: `irq` and `readdata` go to 0 asynchronously, and after release PENDING reads 0.

Source files
------------

// File: rtl/nios_sd_loader_irq_pkg.sv
// Shared constants for the SD-loader interrupt aggregator: register map and
// ACTIVE register layout.
package nios_sd_loader_irq_pkg;

  typedef logic [2:0] irq_addr_t;

  localparam irq_addr_t IRQ_ADDR_PENDING = 3'd0;
  localparam irq_addr_t IRQ_ADDR_MASK    = 3'd1;
  localparam irq_addr_t IRQ_ADDR_MODE    = 3'd2;
  localparam irq_addr_t IRQ_ADDR_FORCE   = 3'd3;
  localparam irq_addr_t IRQ_ADDR_ACTIVE  = 3'd4;
  localparam irq_addr_t IRQ_ADDR_RAW     = 3'd5;

  localparam int unsigned IRQ_MAX_SRC          = 16;
  localparam int unsigned IRQ_ACTIVE_VALID_BIT = 15;

endpackage

// File: rtl/nios_sd_loader_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt aggregator register file.
interface nios_sd_loader_irq_ctrl_if;
  import nios_sd_loader_irq_pkg::*;

  irq_addr_t   address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/nios_sd_loader_irq_prio_enc.sv
// Lowest-index-first priority encoder over the masked pending vector.
module nios_sd_loader_irq_prio_enc #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         id
);

  always_comb begin
    valid = 1'b0;
    id    = 4'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/nios_sd_loader_irq_ctrl.sv
// Interrupt aggregator: per-source level/edge pending latch, mask, registered
// irq to the CPU and an Avalon-MM register file with priority-encoded ACTIVE.
module nios_sd_loader_irq_ctrl
  import nios_sd_loader_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_sd_loader_irq_ctrl_if.slave  bus,
  input  logic [NUM_SRC-1:0]        irq_in,
  output logic                      irq
);

  logic [NUM_SRC-1:0] irq_in_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [15:0]        readdata_q, readdata_d;
  logic               irq_q;

  logic               wr_en;
  logic [NUM_SRC-1:0] wdata;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] force_set;
  logic [NUM_SRC-1:0] rise;
  logic               act_valid;
  logic [3:0]         act_id;
  logic               unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign wdata        = bus.writedata[NUM_SRC-1:0];
  assign unused_wdata = ^bus.writedata;

  assign w1c       = (wr_en && bus.address == IRQ_ADDR_PENDING) ? wdata : '0;
  assign force_set = (wr_en && bus.address == IRQ_ADDR_FORCE)   ? wdata : '0;
  assign rise      = irq_in & ~irq_in_q;

  // Edge sources: set beats clear. Level sources simply follow the input.
  assign pending_d = (mode_q & ((pending_q & ~w1c) | rise | force_set)) |
                     (~mode_q & irq_in);

  assign mask_d = (wr_en && bus.address == IRQ_ADDR_MASK) ? wdata : mask_q;
  assign mode_d = (wr_en && bus.address == IRQ_ADDR_MODE) ? wdata : mode_q;

  nios_sd_loader_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (pending_q & mask_q),
    .valid (act_valid),
    .id    (act_id)
  );

  // Read mux samples pre-write state, so a read concurrent with a write sees old data.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      IRQ_ADDR_PENDING: readdata_d = 16'(pending_q);
      IRQ_ADDR_MASK:    readdata_d = 16'(mask_q);
      IRQ_ADDR_MODE:    readdata_d = 16'(mode_q);
      IRQ_ADDR_ACTIVE: begin
        readdata_d[IRQ_ACTIVE_VALID_BIT] = act_valid;
        readdata_d[3:0]                  = act_id;
      end
      IRQ_ADDR_RAW:     readdata_d = 16'(irq_in_q);
      default:          readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_in_q   <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_in_q   <= irq_in;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_q      <= |(pending_q & mask_q);
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_nios_sd_loader_irq_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the register map and interrupt rules.
module tb_nios_sd_loader_irq_ctrl;

  localparam int unsigned N = 8;
  localparam logic [15:0] NMASK = 16'h00FF;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] irq_in;
  logic         irq;

  int checks = 0;
  int fails  = 0;

  nios_sd_loader_irq_ctrl_if bus ();

  nios_sd_loader_irq_ctrl #(
    .NUM_SRC (N)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_pend = '0, m_mask = '0, m_mode = '0, m_raw = '0, m_rd = '0;
  logic        m_irq = 1'b0;

  function automatic logic [15:0] m_read(input logic [2:0] a);
    logic [15:0] act;
    act = 16'h0000;
    for (int i = 0; i < int'(N); i++) begin
      if (m_pend[i] && m_mask[i]) begin
        act = 16'h8000 | 16'(i);
        break;
      end
    end
    case (a)
      3'd0:    return m_pend;
      3'd1:    return m_mask;
      3'd2:    return m_mode;
      3'd4:    return act;
      3'd5:    return m_raw;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_raw = '0; m_rd = '0; m_irq = 1'b0;
  endtask

  // One clock: model evaluates from current inputs, DUT samples at the edge.
  task automatic cycle();
    logic        wr;
    logic [15:0] wd, in16, np, nrd;
    logic        nirq, set_b, clr_b;
    wr   = bus.chipselect && !bus.write_n;
    wd   = bus.writedata & NMASK;
    in16 = 16'(irq_in);
    nrd  = m_read(bus.address);
    nirq = |(m_pend & m_mask);
    np   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!m_mode[i]) begin
        np[i] = in16[i];
      end else begin
        set_b = (in16[i] && !m_raw[i]) || (wr && bus.address == 3'd3 && wd[i]);
        clr_b = wr && bus.address == 3'd0 && wd[i];
        np[i] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_pend[i]);
      end
    end
    @(posedge clk);
    #1;
    if (wr && bus.address == 3'd1) m_mask = wd;
    if (wr && bus.address == 3'd2) m_mode = wd;
    m_pend = np;
    m_raw  = in16;
    m_rd   = nrd;
    m_irq  = nirq;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    cycle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (irq !== 1'b0 || bus.readdata !== 16'h0000) begin
      fails++;
      $display("FAIL reset_async: irq=%b rd=%h required irq=0 rd=0000", irq, bus.readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus.address = 3'(a);
      cycle();
      checks++;
      if (bus.readdata !== 16'h0000 || irq !== 1'b0) begin
        fails++;
        $display("FAIL reset_read addr %0d: rd=%h irq=%b required 0000/0", a, bus.readdata, irq);
      end
    end
    irq_in = 8'h01;
    bus.address = 3'd0;
    cycle();
    cycle();
    checks++;
    if (bus.readdata !== 16'h0001 || irq !== 1'b0) begin
      fails++;
      $display("FAIL masked_level: rd=%h irq=%b required 0001/0", bus.readdata, irq);
    end
  endtask

  task automatic test_level_pulse();
    irq_in = '0;
    write(3'd1, 16'h0001);
    bus.address = 3'd0;
    cycle();
    cycle();
    for (int c = 0; c < 8; c++) begin
      logic exp;
      irq_in = (c < 3) ? 8'h01 : 8'h00;
      cycle();
      exp = (c >= 1 && c <= 3);
      checks++;
      if (irq !== exp || bus.readdata !== {15'd0, exp}) begin
        fails++;
        $display("FAIL level_pulse c=%0d: irq=%b rd=%h required irq=%b rd=%h",
                 c, irq, bus.readdata, exp, {15'd0, exp});
      end
    end
  endtask

  task automatic test_edge_w1c();
    write(3'd2, 16'h0001);
    bus.address = 3'd0;
    irq_in = 8'h01;
    cycle();
    irq_in = 8'h00;
    repeat (4) cycle();
    checks++;
    if (bus.readdata !== 16'h0001 || irq !== 1'b1) begin
      fails++;
      $display("FAIL edge_latch: rd=%h irq=%b required 0001/1", bus.readdata, irq);
    end
    write(3'd0, 16'h0001);
    checks++;
    if (bus.readdata !== 16'h0001 || irq !== 1'b1) begin
      fails++;
      $display("FAIL read_during_w1c: rd=%h irq=%b required 0001/1", bus.readdata, irq);
    end
    cycle();
    checks++;
    if (bus.readdata !== 16'h0000 || irq !== 1'b0) begin
      fails++;
      $display("FAIL w1c_clear: rd=%h irq=%b required 0000/0", bus.readdata, irq);
    end
  endtask

  task automatic test_set_wins();
    irq_in = 8'h01;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 16'h0001;
    cycle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    irq_in = 8'h00;
    cycle();
    checks++;
    if (bus.readdata !== 16'h0001) begin
      fails++;
      $display("FAIL set_wins: rd=%h required 0001", bus.readdata);
    end
    write(3'd0, 16'h0001);
    cycle();
  endtask

  task automatic test_force_active();
    write(3'd2, 16'h000D);
    write(3'd1, 16'h000C);
    write(3'd3, 16'h000C);
    bus.address = 3'd4;
    cycle();
    checks++;
    if (bus.readdata !== 16'h8002) begin
      fails++;
      $display("FAIL active_2: rd=%h required 8002", bus.readdata);
    end
    write(3'd0, 16'h0004);
    bus.address = 3'd4;
    cycle();
    checks++;
    if (bus.readdata !== 16'h8003) begin
      fails++;
      $display("FAIL active_3: rd=%h required 8003", bus.readdata);
    end
    write(3'd0, 16'h0008);
    bus.address = 3'd4;
    cycle();
    checks++;
    if (bus.readdata !== 16'h0000) begin
      fails++;
      $display("FAIL active_none: rd=%h required 0000", bus.readdata);
    end
  endtask

  task automatic test_reset_mid();
    write(3'd2, 16'h008D);
    write(3'd1, 16'h0081);
    write(3'd3, 16'h0081);
    bus.address = 3'd0;
    cycle();
    cycle();
    checks++;
    if (irq !== 1'b1 || bus.readdata !== 16'h0081) begin
      fails++;
      $display("FAIL pre_reset: irq=%b rd=%h required 1/0081", irq, bus.readdata);
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (irq !== 1'b0 || bus.readdata !== 16'h0000) begin
      fails++;
      $display("FAIL mid_reset_async: irq=%b rd=%h required 0/0000", irq, bus.readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    cycle();
    checks++;
    if (bus.readdata !== 16'h0000 || irq !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_pending: rd=%h irq=%b required 0000/0", bus.readdata, irq);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      irq_in         = N'($urandom);
      bus.chipselect = ($urandom_range(0, 3) == 0);
      bus.write_n    = 1'($urandom_range(0, 1));
      bus.address    = 3'($urandom_range(0, 7));
      bus.writedata  = 16'($urandom);
      cycle();
      checks++;
      if (bus.readdata !== m_rd || irq !== m_irq) begin
        fails++;
        $display("FAIL random c=%0d: rd=%h irq=%b required rd=%h irq=%b",
                 c, bus.readdata, irq, m_rd, m_irq);
      end
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  initial begin
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0000;
    irq_in         = '0;
    test_reset();
    test_level_pulse();
    test_edge_w1c();
    test_set_wins();
    test_force_active();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
